// File: rtl/vend_ctrl_p.sv
// vend_ctrl_p: vending machine controller.
// Coins and buttons are registered and edge-detected. Credit saturates at
// MAX_CREDIT, and a purchase holds dispense high for VEND_HOLD cycles.
// Optional feature: define VEND_CTRL_REFUND_EN to enable the refund button
// and the REFUND state.
module vend_ctrl_p #(
    parameter int N_ITEMS    = 5,
    parameter int CREDIT_W   = 8,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd8, 8'd10, 8'd6, 8'd5, 8'd7},
    parameter int MAX_CREDIT = 79,
    parameter int VEND_HOLD  = 4,
    localparam int SEL_W     = $clog2(N_ITEMS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          coin_in,
    input  logic                L_button,
    input  logic                R_button,
    input  logic                C_button,
    input  logic                refund_button,
    output logic [CREDIT_W-1:0] credit,
    output logic [SEL_W-1:0]    sel,
    output logic [CREDIT_W-1:0] sel_price,
    output logic [N_ITEMS-1:0]  afford,
    output logic                dispense,
    output logic [SEL_W-1:0]    dispense_item,
    output logic                deny,
    output logic                coin_reject,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_amount,
    output logic                busy
);

    localparam int SUM_W = CREDIT_W + 7;

    typedef enum logic [1:0] {IDLE, BROWSE, VEND, REFUND} state_t;

`ifdef VEND_CTRL_REFUND_EN
    localparam int NB = 4;
    logic [NB-1:0] btn_raw;
    assign btn_raw = {refund_button, C_button, R_button, L_button};
`else
    localparam int NB = 3;
    logic [NB-1:0] btn_raw;
    logic unused_refund;
    assign btn_raw = {C_button, R_button, L_button};
    assign unused_refund = refund_button;
`endif

    state_t              state, state_n;
    logic [3:0]          coin_q, coin_qq, coin_e;
    logic [NB-1:0]       btn_q, btn_qq, btn_e;
    logic [1:0]          vld;
    logic [CREDIT_W-1:0] credit_n, added;
    logic [SEL_W-1:0]    sel_n, item_n;
    logic [7:0]          hold_cnt, hold_n;
    logic                deny_n, reject_n;
    logic [5:0]          coin_sum;
    logic [SUM_W-1:0]    sum;
    logic                over;

    // Edges count only once both sample stages hold post-reset data, so held inputs never fire
    always_comb begin
        coin_e = coin_q & ~coin_qq & {4{vld[1]}};
        btn_e  = btn_q & ~btn_qq & {NB{vld[1]}};
    end

    // Coin value of this cycle's edges, credit plus coins, and the saturated result
    always_comb begin
        coin_sum = (coin_e[0] ? 6'd1  : 6'd0) + (coin_e[1] ? 6'd5  : 6'd0)
                 + (coin_e[2] ? 6'd10 : 6'd0) + (coin_e[3] ? 6'd20 : 6'd0);
        sum      = SUM_W'(credit) + SUM_W'(coin_sum);
        over     = sum > SUM_W'(MAX_CREDIT);
        added    = over ? CREDIT_W'(MAX_CREDIT) : sum[CREDIT_W-1:0];
    end

    // Price lookup and per-item affordability from registered credit and selection
    assign sel_price = PRICES[int'(sel)*CREDIT_W +: CREDIT_W];
    for (genvar i = 0; i < N_ITEMS; i++) begin : g_afford
        assign afford[i] = credit >= PRICES[i*CREDIT_W +: CREDIT_W];
    end

    // Next-state logic: purchases are checked against pre-coin credit, C beats refund beats L/R
    always_comb begin
        state_n  = state;
        credit_n = credit;
        sel_n    = sel;
        item_n   = dispense_item;
        hold_n   = hold_cnt;
        deny_n   = 1'b0;
        reject_n = 1'b0;
        case (state)
            IDLE: begin
                credit_n = added;
                reject_n = over;
                if (credit != '0) state_n = BROWSE;
            end
            BROWSE: begin
                credit_n = added;
                reject_n = over;
                if (btn_e[2]) begin
                    if (credit >= sel_price) begin
                        credit_n = added - sel_price;
                        item_n   = sel;
                        hold_n   = 8'(VEND_HOLD - 1);
                        state_n  = VEND;
                    end else begin
                        deny_n = 1'b1;
                    end
                end
`ifdef VEND_CTRL_REFUND_EN
                else if (btn_e[3]) begin
                    state_n = REFUND;
                end
`endif
                else if (btn_e[0] && !btn_e[1]) begin
                    sel_n = (sel == '0) ? SEL_W'(N_ITEMS - 1) : sel - SEL_W'(1);
                end else if (btn_e[1] && !btn_e[0]) begin
                    sel_n = (sel == SEL_W'(N_ITEMS - 1)) ? '0 : sel + SEL_W'(1);
                end
            end
            VEND: begin
                credit_n = added;
                reject_n = over;
                if (hold_cnt == 8'd0) begin
                    state_n = (credit_n != '0) ? BROWSE : IDLE;
                end else begin
                    hold_n = hold_cnt - 8'd1;
                end
            end
            REFUND: begin
`ifdef VEND_CTRL_REFUND_EN
                credit_n = '0;
                reject_n = |coin_e;
`endif
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, credit, selection, input sample registers and registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            credit        <= '0;
            sel           <= '0;
            dispense_item <= '0;
            hold_cnt      <= '0;
            deny          <= 1'b0;
            coin_reject   <= 1'b0;
            coin_q        <= '0;
            coin_qq       <= '0;
            btn_q         <= '0;
            btn_qq        <= '0;
            vld           <= '0;
        end else begin
            state         <= state_n;
            credit        <= credit_n;
            sel           <= sel_n;
            dispense_item <= item_n;
            hold_cnt      <= hold_n;
            deny          <= deny_n;
            coin_reject   <= reject_n;
            coin_q        <= coin_in;
            coin_qq       <= coin_q;
            btn_q         <= btn_raw;
            btn_qq        <= btn_q;
            vld           <= {vld[0], 1'b1};
        end
    end

    assign dispense = (state == VEND);
    assign busy     = (state == VEND) || (state == REFUND);

`ifdef VEND_CTRL_REFUND_EN
    assign refund_valid  = (state == REFUND);
    assign refund_amount = refund_valid ? credit : '0;
`else
    assign refund_valid  = 1'b0;
    assign refund_amount = '0;
`endif

endmodule

// File: tb/tb_vend_ctrl_p.sv
// Scoreboard testbench for vend_ctrl_p with default parameters.
// A behavioural model pushes expected results per transaction, which are
// compared once the transaction has settled.
module tb_vend_ctrl_p;

    localparam int N    = 5;
    localparam int MAXC = 79;
    localparam int HOLD = 4;
`ifdef VEND_CTRL_REFUND_EN
    localparam bit REFUND_ON = 1'b1;
`else
    localparam bit REFUND_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] coin_in;
    logic       L_button, R_button, C_button, refund_button;
    logic [7:0] credit, sel_price, refund_amount;
    logic [2:0] sel, dispense_item;
    logic [4:0] afford;
    logic       dispense, deny, coin_reject, refund_valid, busy;

    vend_ctrl_p dut (
        .clk(clk), .rst(rst), .coin_in(coin_in),
        .L_button(L_button), .R_button(R_button), .C_button(C_button),
        .refund_button(refund_button),
        .credit(credit), .sel(sel), .sel_price(sel_price), .afford(afford),
        .dispense(dispense), .dispense_item(dispense_item), .deny(deny),
        .coin_reject(coin_reject), .refund_valid(refund_valid),
        .refund_amount(refund_amount), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int credit; int sel; int denyN; int rejectN;
        int dispN; int item; int refundN; int refundAmt;
    } exp_t;

    exp_t sbQ[$];
    int   price[N] = '{7, 5, 6, 10, 8};
    int   compared = 0, mismatched = 0;
    int   denyCnt, rejectCnt, dispCnt, refundCnt, lastItem, lastRefund;
    int   mCredit, mSel;
    bit   mBrowse;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output pulse counters, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (deny)        denyCnt++;
        if (coin_reject) rejectCnt++;
        if (dispense) begin dispCnt++; lastItem = int'(dispense_item); end
        if (refund_valid) begin refundCnt++; lastRefund = int'(refund_amount); end
    end

    function automatic int coinValue(input logic [3:0] c);
        return (c[0] ? 1 : 0) + (c[1] ? 5 : 0) + (c[2] ? 10 : 0) + (c[3] ? 20 : 0);
    endfunction

    task automatic clearCounters();
        denyCnt = 0; rejectCnt = 0; dispCnt = 0; refundCnt = 0;
        lastItem = -1; lastRefund = -1;
    endtask

    task automatic releaseInputs();
        coin_in = 4'b0; L_button = 0; R_button = 0; C_button = 0; refund_button = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        releaseInputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mCredit = 0; mSel = 0; mBrowse = 1'b0;
    endtask

    task automatic drainScoreboard();
        exp_t e;
        int   a;
        e = sbQ.pop_front();
        a = 0;
        for (int i = 0; i < N; i++) if (e.credit >= price[i]) a |= (1 << i);
        checkOutput("credit", credit, e.credit);
        checkOutput("sel", sel, e.sel);
        checkOutput("deny_pulses", denyCnt, e.denyN);
        checkOutput("reject_pulses", rejectCnt, e.rejectN);
        checkOutput("dispense_cycles", dispCnt, e.dispN);
        if (e.dispN > 0) checkOutput("dispense_item", lastItem, e.item);
        checkOutput("refund_pulses", refundCnt, e.refundN);
        if (e.refundN > 0) checkOutput("refund_amount", lastRefund, e.refundAmt);
        checkOutput("afford", afford, a);
        checkOutput("sel_price", sel_price, price[e.sel]);
        checkOutput("busy_idle", busy, 0);
    endtask

    // Model one transaction, push its expectation, pulse the inputs and compare after settling
    task automatic applyStimulus(input logic [3:0] coins, input bit l, input bit r,
                                 input bit c, input bit rf);
        exp_t e;
        int   added;
        e = '{default: 0};
        added = mCredit + coinValue(coins);
        if (added > MAXC) begin added = MAXC; e.rejectN = 1; end
        if (mBrowse && c) begin
            if (mCredit >= price[mSel]) begin
                e.dispN = HOLD; e.item = mSel; mCredit = added - price[mSel];
            end else begin
                e.denyN = 1; mCredit = added;
            end
        end else if (mBrowse && rf && REFUND_ON) begin
            e.refundN = 1; e.refundAmt = added; mCredit = 0;
        end else begin
            mCredit = added;
            if (mBrowse && l && !r)      mSel = (mSel + N - 1) % N;
            else if (mBrowse && r && !l) mSel = (mSel + 1) % N;
        end
        mBrowse  = (mCredit != 0);
        e.credit = mCredit;
        e.sel    = mSel;
        sbQ.push_back(e);

        @(negedge clk);
        clearCounters();
        coin_in = coins; L_button = l; R_button = r; C_button = c; refund_button = rf;
        @(negedge clk);
        releaseInputs();
        repeat (10) @(negedge clk);
        drainScoreboard();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        releaseInputs();
        clearCounters();
        repeat (3) @(negedge clk);
        checkOutput("rst_credit", credit, 0);
        checkOutput("rst_sel", sel, 0);
        checkOutput("rst_dispense", dispense, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_deny", deny, 0);
        checkOutput("rst_reject", coin_reject, 0);
        checkOutput("rst_refund", refund_valid, 0);
        rst = 1'b0;
        mCredit = 0; mSel = 0; mBrowse = 1'b0;

        // Insert 10, buy item 0, then browse with wrap-around and simultaneous L/R
        applyStimulus(4'b0100, 0, 0, 0, 0);
        applyStimulus(4'b0000, 0, 0, 1, 0);
        applyStimulus(4'b0000, 1, 0, 0, 0);
        applyStimulus(4'b0000, 0, 1, 0, 0);
        applyStimulus(4'b0000, 1, 1, 0, 0);

        // Credit 5 at item 4 is denied
        doReset();
        applyStimulus(4'b0010, 0, 0, 0, 0);
        applyStimulus(4'b0000, 1, 0, 0, 0);
        applyStimulus(4'b0000, 0, 0, 1, 0);

        // Coin and C together: the decision uses pre-coin credit
        doReset();
        repeat (3) applyStimulus(4'b0001, 0, 0, 0, 0);
        applyStimulus(4'b0000, 0, 1, 0, 0);
        applyStimulus(4'b0010, 0, 0, 1, 0);
        applyStimulus(4'b0001, 0, 0, 1, 0);

        // Saturation at MAX_CREDIT, then buy item 3
        doReset();
        repeat (3) applyStimulus(4'b1000, 0, 0, 0, 0);
        applyStimulus(4'b0100, 0, 0, 0, 0);
        applyStimulus(4'b1000, 0, 0, 0, 0);
        applyStimulus(4'b0001, 0, 0, 0, 0);
        applyStimulus(4'b0000, 1, 0, 0, 0);
        applyStimulus(4'b0000, 1, 0, 0, 0);
        applyStimulus(4'b0000, 0, 0, 1, 0);

        // Refund with credit 12
        doReset();
        applyStimulus(4'b0100, 0, 0, 0, 0);
        applyStimulus(4'b0001, 0, 0, 0, 0);
        applyStimulus(4'b0001, 0, 0, 0, 0);
        applyStimulus(4'b0000, 0, 0, 0, 1);

        // Reset asserted mid-vend aborts dispensing
        doReset();
        applyStimulus(4'b0100, 0, 0, 0, 0);
        @(negedge clk);
        C_button = 1'b1;
        @(negedge clk);
        C_button = 1'b0;
        k = 0;
        while (!dispense && k < 10) begin @(negedge clk); k++; end
        checkOutput("vend_started", dispense, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_vend_dispense", dispense, 0);
        checkOutput("rst_mid_vend_busy", busy, 0);
        rst = 1'b0;
        clearCounters();
        repeat (8) @(negedge clk);
        checkOutput("post_rst_dispense_cycles", dispCnt, 0);
        checkOutput("post_rst_credit", credit, 0);
        mCredit = 0; mSel = 0; mBrowse = 1'b0;

        // A coin held through reset release is not an event
        @(negedge clk);
        rst = 1'b1;
        coin_in = 4'b0100;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("held_coin_credit", credit, 0);
        coin_in = 4'b0000;
        repeat (3) @(negedge clk);
        checkOutput("held_coin_released_credit", credit, 0);
        applyStimulus(4'b0100, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_p.md
VEND_CTRL_P -- requirements
Module: vend_ctrl_p

Interface
REQ-001 SHALL have parameter N_ITEMS, default 5, number of selectable items (2..16).
REQ-002 SHALL have parameter CREDIT_W, default 8, width of credit and price values.
REQ-003 SHALL have parameter PRICES, default {8'd8,8'd10,8'd6,8'd5,8'd7}, packed N_ITEMS*CREDIT_W vector with item i at bits [i*CREDIT_W +: CREDIT_W]; defaults are item0=7, item1=5, item2=6, item3=10, item4=8.
REQ-004 SHALL have parameter MAX_CREDIT, default 79, the credit saturation ceiling.
REQ-005 SHALL have parameter VEND_HOLD, default 4, the number of cycles dispense is held (1..255).
REQ-006 SHALL have ports: clk  in  1  single clock; rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: coin_in  in  4  coin level inputs with values 1, 5, 10 and 20 for bits 0..3; L_button  in  1  select previous; R_button  in  1  select next; C_button  in  1  confirm purchase; refund_button  in  1  return credit.
REQ-008 SHALL have ports: credit  out  CREDIT_W  current credit; sel  out  SEL_W=$clog2(N_ITEMS)  selected index; sel_price  out  CREDIT_W  price of sel; afford  out  N_ITEMS  bit i set when credit >= price i.
REQ-009 SHALL have ports: dispense  out  1  item release; dispense_item  out  SEL_W  item being released; deny  out  1  one-cycle pulse; coin_reject  out  1  one-cycle pulse; refund_valid  out  1  one-cycle pulse; refund_amount  out  CREDIT_W  amount refunded; busy  out  1  high in VEND or REFUND.

Function
REQ-010 SHALL register all inputs once and act only on rising edges (0->1 between consecutive registered samples), so that one press or coin produces one event.
REQ-011 SHALL be a state machine with states IDLE, BROWSE, VEND and REFUND.
REQ-012 SHALL stay in IDLE while credit is 0 and move to BROWSE in the cycle after credit becomes nonzero.
REQ-013 SHALL, in BROWSE, act on an L edge alone by setting sel to sel-1, wrapping from 0 to N_ITEMS-1.
REQ-014 SHALL, in BROWSE, act on an R edge alone by setting sel to sel+1, wrapping from N_ITEMS-1 to 0.
REQ-015 SHALL leave sel unchanged when L and R edges occur in the same cycle.
REQ-016 SHALL, on a C edge in BROWSE with credit >= sel_price, subtract the price, latch dispense_item=sel and enter VEND.
REQ-017 SHALL, on a C edge in BROWSE with credit < sel_price, pulse deny for one cycle and stay in BROWSE.
REQ-018 SHALL give a C edge priority over L and R edges in the same cycle; L and R are then ignored.
REQ-019 SHALL hold dispense high for exactly VEND_HOLD cycles in VEND, ignoring L, R, C and refund edges.
REQ-020 SHALL leave VEND for BROWSE if credit is nonzero, otherwise for IDLE.
REQ-021 SHALL, in IDLE, BROWSE and VEND, add all coin edges of a cycle together into credit.
REQ-022 SHALL compare a purchase against the pre-coin credit when a coin edge and a C edge fall in the same cycle, then compute credit_next = credit + coins - price.
REQ-023 SHALL clamp credit at MAX_CREDIT when an addition exceeds it and pulse coin_reject in that cycle; credit SHALL never wrap.
REQ-024 SHALL continuously drive afford and sel_price from the registered credit and sel.
REQ-025 SHALL keep busy high exactly while the state is VEND or REFUND.

Reset
REQ-026 SHALL, while rst is high at a clk edge, force: state IDLE, credit 0, sel 0, dispense_item 0, edge registers 0, and dispense, deny, coin_reject, refund_valid, refund_amount and busy all 0.
REQ-027 SHALL abort any VEND or REFUND in progress when reset is asserted mid-operation, with no further dispense or refund pulse.
REQ-028 SHALL treat buttons already held high when reset is released as not pressed; an edge requires a release first.

Configuration
REQ-029 SHALL, with macro VEND_CTRL_REFUND_EN defined, enter REFUND on a refund_button edge in BROWSE, pulse refund_valid with refund_amount equal to credit, clear credit, and enter IDLE on the next cycle.
REQ-030 SHALL, with VEND_CTRL_REFUND_EN defined, pulse coin_reject and leave credit unchanged on a coin edge during REFUND.
REQ-031 SHALL, with VEND_CTRL_REFUND_EN undefined, ignore refund_button, never enter REFUND, and tie refund_valid and refund_amount to 0.

Verification
REQ-032 SHALL pass: defaults, insert 10 (bit2), press C at sel 0 -> credit=3, dispense high 4 cycles, dispense_item=0, state BROWSE.
REQ-033 SHALL pass: credit 5, sel 4, press C -> deny pulses once, credit stays 5, no dispense.
REQ-034 SHALL pass: sel 0, press L -> sel=4; press R -> sel=0; press L and R together -> sel unchanged.
REQ-035 SHALL pass: credit 70, insert 20 -> credit=79, coin_reject pulses once.
REQ-036 SHALL pass: credit 3, coin 5 and C at sel 1 (price 5) in the same cycle -> deny pulses, credit=8.
REQ-037 SHALL pass: with VEND_CTRL_REFUND_EN defined and credit 12, press refund -> refund_valid pulses with refund_amount=12, then credit=0 and state IDLE; reset asserted during VEND -> dispense low in the next cycle.
